// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 sequencer: opcodes, FSM states, LOAD bit
// indices and the instruction decoder.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  localparam logic [3:0] LOAD_NONE = 4'b1111;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_PCU   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_A    = 2'd1,
    SRC_B    = 2'd2,
    SRC_IN   = 2'd3
  } src_t;

  typedef struct packed {
    src_t       src;
    logic [3:0] load_n;   // active-low LOAD pattern for the WB cycle
    logic       is_data;  // data ops update carry; jumps/undefined clear it
  } decode_t;

  function automatic logic [3:0] ld_mask(input int idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic decode_t decode(input logic [3:0] op);
    decode_t d;
    d = '{src: SRC_ZERO, load_n: LOAD_NONE, is_data: 1'b0};
    case (op)
      OP_ADD_A:  d = '{src: SRC_A,    load_n: ld_mask(LD_A),   is_data: 1'b1};
      OP_MOV_AB: d = '{src: SRC_B,    load_n: ld_mask(LD_A),   is_data: 1'b1};
      OP_IN_A:   d = '{src: SRC_IN,   load_n: ld_mask(LD_A),   is_data: 1'b1};
      OP_MOV_A:  d = '{src: SRC_ZERO, load_n: ld_mask(LD_A),   is_data: 1'b1};
      OP_MOV_BA: d = '{src: SRC_A,    load_n: ld_mask(LD_B),   is_data: 1'b1};
      OP_ADD_B:  d = '{src: SRC_B,    load_n: ld_mask(LD_B),   is_data: 1'b1};
      OP_IN_B:   d = '{src: SRC_IN,   load_n: ld_mask(LD_B),   is_data: 1'b1};
      OP_MOV_B:  d = '{src: SRC_ZERO, load_n: ld_mask(LD_B),   is_data: 1'b1};
      OP_OUT_B:  d = '{src: SRC_B,    load_n: ld_mask(LD_OUT), is_data: 1'b1};
      OP_OUT_IM: d = '{src: SRC_ZERO, load_n: ld_mask(LD_OUT), is_data: 1'b1};
      default:   d = '{src: SRC_ZERO, load_n: LOAD_NONE,       is_data: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/td4_alu.sv
// Combinational adder for the TD4 datapath: a + b -> {carry, sum}.
module td4_alu #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_sum,
  output logic          o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control sequencer: fetch/decode/execute over four cycles, driving the
// register file's active-low LOAD enables and IN_DATA write bus.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int DW = 4,
  parameter int IW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RUN,
  input  logic [IW-1:0] ROM_DATA,
  input  logic [DW-1:0] ADDRESS,
  input  logic [DW-1:0] OUT_A,
  input  logic [DW-1:0] OUT_B,
  input  logic [DW-1:0] IN_PORT,
  output logic [DW-1:0] ROM_ADDR,
  output logic [3:0]    LOAD,
  output logic [DW-1:0] IN_DATA,
  output logic          CARRY
);

  state_t        r_state;
  logic [IW-1:0] r_ir;
  logic [3:0]    r_load;
  logic [DW-1:0] r_in_data;
  logic          r_carry;
  logic          r_taken;

  logic [IW-DW-1:0] w_op;
  logic [DW-1:0]    w_imm;
  logic [DW-1:0]    w_src;
  logic [DW-1:0]    w_sum;
  logic             w_c;
  decode_t          w_dec;

  assign w_op     = r_ir[IW-1:DW];
  assign w_imm    = r_ir[DW-1:0];
  assign w_dec    = decode(w_op);
  assign ROM_ADDR = ADDRESS;
  assign LOAD     = r_load;
  assign IN_DATA  = r_in_data;
  assign CARRY    = r_carry;

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    w_src = '0;
    case (w_dec.src)
      SRC_A:   w_src = OUT_A;
      SRC_B:   w_src = OUT_B;
      SRC_IN:  w_src = IN_PORT;
      default: w_src = '0;
    endcase
  end

  td4_alu #(.DW(DW)) u_alu (
    .i_a    (w_src),
    .i_b    (w_imm),
    .o_sum  (w_sum),
    .o_carry(w_c)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_load    <= LOAD_NONE;
      r_in_data <= '0;
      r_carry   <= 1'b0;
      r_taken   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_load <= LOAD_NONE;
          if (RUN) begin
            r_ir    <= ROM_DATA;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // JNC tests the carry left by the previous instruction, before it is overwritten here.
          r_taken   <= (w_op == OP_JMP) || ((w_op == OP_JNC) && !r_carry);
          r_carry   <= w_dec.is_data & w_c;
          r_load    <= w_dec.load_n;
          r_in_data <= w_sum;
          r_state   <= S_WB;
        end
        S_WB: begin
          r_load    <= ld_mask(LD_PC);
          r_in_data <= r_taken ? w_imm : ADDRESS + {{(DW-1){1'b0}}, 1'b1};
          r_state   <= S_PCU;
        end
        S_PCU: begin
          r_load  <= LOAD_NONE;
          r_state <= S_FETCH;
        end
        default: begin
          r_load  <= LOAD_NONE;
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer with a behavioural register file and ROM.
module tb_td4_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RUN = 1'b0;
  logic [7:0] ROM_DATA;
  logic [3:0] ADDRESS;
  logic [3:0] OUT_A;
  logic [3:0] OUT_B;
  logic [3:0] IN_PORT = 4'h0;
  logic [3:0] ROM_ADDR;
  logic [3:0] LOAD;
  logic [3:0] IN_DATA;
  logic       CARRY;

  logic [7:0] rom [16];
  logic [3:0] ra = 4'h0, rb = 4'h0, rout = 4'h0, rpc = 4'h0;
  logic       pre_en = 1'b0;
  logic [3:0] pre_a = 4'h0, pre_b = 4'h0, pre_out = 4'h0, pre_pc = 4'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  td4_sequencer dut (
    .CLK     (CLK),
    .RST     (RST),
    .RUN     (RUN),
    .ROM_DATA(ROM_DATA),
    .ADDRESS (ADDRESS),
    .OUT_A   (OUT_A),
    .OUT_B   (OUT_B),
    .IN_PORT (IN_PORT),
    .ROM_ADDR(ROM_ADDR),
    .LOAD    (LOAD),
    .IN_DATA (IN_DATA),
    .CARRY   (CARRY)
  );

  assign ROM_DATA = rom[ROM_ADDR];
  assign ADDRESS  = rpc;
  assign OUT_A    = ra;
  assign OUT_B    = rb;

  // Register file model: active-low enables captured on the rising edge.
  always @(posedge CLK) begin
    if (pre_en) begin
      ra <= pre_a; rb <= pre_b; rout <= pre_out; rpc <= pre_pc;
    end else begin
      if (!LOAD[0]) ra   <= IN_DATA;
      if (!LOAD[1]) rb   <= IN_DATA;
      if (!LOAD[2]) rout <= IN_DATA;
      if (!LOAD[3]) rpc  <= IN_DATA;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic preset(input logic [3:0] a, b, o, pc);
    @(negedge CLK);
    pre_a = a; pre_b = b; pre_out = o; pre_pc = pc; pre_en = 1'b1;
    step();
    pre_en = 1'b0;
  endtask

  // Runs one instruction from FETCH and records what each state presented.
  task automatic run_instr(output logic [3:0] exec_load, wb_load, wb_data,
                           output logic wb_carry,
                           output logic [3:0] pcu_load, pcu_data, fetch_load);
    RUN = 1'b1;
    step();
    RUN = 1'b0;
    exec_load = LOAD;
    step();
    wb_load = LOAD; wb_data = IN_DATA; wb_carry = CARRY;
    step();
    pcu_load = LOAD; pcu_data = IN_DATA;
    step();
    fetch_load = LOAD;
  endtask

  task automatic test_reset();
    RST = 1'b0; RUN = 1'b0;
    step();
    n_cmp++; if (LOAD !== 4'b1111) begin n_bad++; $display("FAIL reset_load got=%b exp=1111", LOAD); end
    n_cmp++; if (IN_DATA !== 4'h0) begin n_bad++; $display("FAIL reset_in_data got=%h exp=0", IN_DATA); end
    n_cmp++; if (CARRY !== 1'b0) begin n_bad++; $display("FAIL reset_carry got=%b exp=0", CARRY); end
    @(negedge CLK);
    RST = 1'b1;
    step();
    n_cmp++; if (LOAD !== 4'b1111) begin n_bad++; $display("FAIL idle_load got=%b exp=1111", LOAD); end
  endtask

  task automatic test_add_overflow();
    logic [3:0] el, wl, wd, pl, pd, fl; logic wc;
    preset(4'hF, 4'h0, 4'h0, 4'h0);
    rom[0] = 8'h01;
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (el !== 4'b1111) begin n_bad++; $display("FAIL add_exec_load got=%b exp=1111", el); end
    n_cmp++; if (wl !== 4'b1110) begin n_bad++; $display("FAIL add_wb_load got=%b exp=1110", wl); end
    n_cmp++; if (wd !== 4'h0) begin n_bad++; $display("FAIL add_wb_data got=%h exp=0", wd); end
    n_cmp++; if (wc !== 1'b1) begin n_bad++; $display("FAIL add_carry got=%b exp=1", wc); end
    n_cmp++; if (pl !== 4'b0111) begin n_bad++; $display("FAIL add_pcu_load got=%b exp=0111", pl); end
    n_cmp++; if (pd !== 4'h1) begin n_bad++; $display("FAIL add_pcu_data got=%h exp=1", pd); end
    n_cmp++; if (fl !== 4'b1111) begin n_bad++; $display("FAIL add_fetch_load got=%b exp=1111", fl); end
    n_cmp++; if (ra !== 4'h0) begin n_bad++; $display("FAIL add_reg_a got=%h exp=0", ra); end
    n_cmp++; if (rpc !== 4'h1) begin n_bad++; $display("FAIL add_pc got=%h exp=1", rpc); end
  endtask

  task automatic test_jnc();
    logic [3:0] el, wl, wd, pl, pd, fl; logic wc;
    rom[1] = 8'hE9;
    rom[2] = 8'hE9;
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wl !== 4'b1111) begin n_bad++; $display("FAIL jnc_nt_wb_load got=%b exp=1111", wl); end
    n_cmp++; if (wc !== 1'b0) begin n_bad++; $display("FAIL jnc_nt_carry got=%b exp=0", wc); end
    n_cmp++; if (pd !== 4'h2) begin n_bad++; $display("FAIL jnc_nt_pcu_data got=%h exp=2", pd); end
    n_cmp++; if (rpc !== 4'h2) begin n_bad++; $display("FAIL jnc_nt_pc got=%h exp=2", rpc); end
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (pl !== 4'b0111) begin n_bad++; $display("FAIL jnc_t_pcu_load got=%b exp=0111", pl); end
    n_cmp++; if (pd !== 4'h9) begin n_bad++; $display("FAIL jnc_t_pcu_data got=%h exp=9", pd); end
    n_cmp++; if (rpc !== 4'h9) begin n_bad++; $display("FAIL jnc_t_pc got=%h exp=9", rpc); end
  endtask

  task automatic test_jmp_wrap();
    logic [3:0] el, wl, wd, pl, pd, fl; logic wc;
    preset(4'h0, 4'h0, 4'h0, 4'h0);
    rom[0]  = 8'hFF;
    rom[15] = 8'h35;
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wl !== 4'b1111) begin n_bad++; $display("FAIL jmp_wb_load got=%b exp=1111", wl); end
    n_cmp++; if (pd !== 4'hF) begin n_bad++; $display("FAIL jmp_pcu_data got=%h exp=F", pd); end
    n_cmp++; if (rpc !== 4'hF) begin n_bad++; $display("FAIL jmp_pc got=%h exp=F", rpc); end
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wl !== 4'b1110) begin n_bad++; $display("FAIL mov_wb_load got=%b exp=1110", wl); end
    n_cmp++; if (wd !== 4'h5) begin n_bad++; $display("FAIL mov_wb_data got=%h exp=5", wd); end
    n_cmp++; if (wc !== 1'b0) begin n_bad++; $display("FAIL mov_carry got=%b exp=0", wc); end
    n_cmp++; if (pd !== 4'h0) begin n_bad++; $display("FAIL wrap_pcu_data got=%h exp=0", pd); end
    n_cmp++; if (ra !== 4'h5) begin n_bad++; $display("FAIL mov_reg_a got=%h exp=5", ra); end
    n_cmp++; if (rpc !== 4'h0) begin n_bad++; $display("FAIL wrap_pc got=%h exp=0", rpc); end
  endtask

  task automatic test_out_undefined();
    logic [3:0] el, wl, wd, pl, pd, fl; logic wc;
    rom[0] = 8'hB6;
    rom[1] = 8'h0F;
    rom[2] = 8'h80;
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wl !== 4'b1011) begin n_bad++; $display("FAIL outim_wb_load got=%b exp=1011", wl); end
    n_cmp++; if (wd !== 4'h6) begin n_bad++; $display("FAIL outim_wb_data got=%h exp=6", wd); end
    n_cmp++; if (rout !== 4'h6) begin n_bad++; $display("FAIL outim_reg_out got=%h exp=6", rout); end
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wd !== 4'h4) begin n_bad++; $display("FAIL add_a_wb_data got=%h exp=4", wd); end
    n_cmp++; if (wc !== 1'b1) begin n_bad++; $display("FAIL add_a_carry got=%b exp=1", wc); end
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wl !== 4'b1111) begin n_bad++; $display("FAIL undef_wb_load got=%b exp=1111", wl); end
    n_cmp++; if (wc !== 1'b0) begin n_bad++; $display("FAIL undef_carry got=%b exp=0", wc); end
    n_cmp++; if (pd !== 4'h3) begin n_bad++; $display("FAIL undef_pcu_data got=%h exp=3", pd); end
    n_cmp++; if (ra !== 4'h4) begin n_bad++; $display("FAIL undef_reg_a got=%h exp=4", ra); end
    n_cmp++; if (rpc !== 4'h3) begin n_bad++; $display("FAIL undef_pc got=%h exp=3", rpc); end
  endtask

  task automatic test_run_hold();
    logic [3:0] el, wl, wd, pl, pd, fl; logic wc;
    rom[3] = 8'h52;
    RUN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (LOAD !== 4'b1111) begin n_bad++; $display("FAIL hold_load[%0d] got=%b exp=1111", i, LOAD); end
    end
    n_cmp++; if (rpc !== 4'h3) begin n_bad++; $display("FAIL hold_pc got=%h exp=3", rpc); end
    n_cmp++; if (rb !== 4'h0) begin n_bad++; $display("FAIL hold_reg_b got=%h exp=0", rb); end
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wl !== 4'b1101) begin n_bad++; $display("FAIL addb_wb_load got=%b exp=1101", wl); end
    n_cmp++; if (wd !== 4'h2) begin n_bad++; $display("FAIL addb_wb_data got=%h exp=2", wd); end
    n_cmp++; if (rb !== 4'h2) begin n_bad++; $display("FAIL addb_reg_b got=%h exp=2", rb); end
    n_cmp++; if (rpc !== 4'h4) begin n_bad++; $display("FAIL addb_pc got=%h exp=4", rpc); end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] el, wl, wd, pl, pd, fl; logic wc;
    preset(4'h3, 4'h0, 4'h0, 4'h0);
    rom[0] = 8'h37;
    RUN = 1'b1;
    step();
    RUN = 1'b0;
    step();
    n_cmp++; if (LOAD !== 4'b1110) begin n_bad++; $display("FAIL mid_wb_load got=%b exp=1110", LOAD); end
    RST = 1'b0;
    #1;
    n_cmp++; if (LOAD !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_load got=%b exp=1111", LOAD); end
    n_cmp++; if (IN_DATA !== 4'h0) begin n_bad++; $display("FAIL mid_rst_in_data got=%h exp=0", IN_DATA); end
    step();
    step();
    @(negedge CLK);
    RST = 1'b1;
    step();
    n_cmp++; if (ra !== 4'h3) begin n_bad++; $display("FAIL mid_reg_a got=%h exp=3", ra); end
    n_cmp++; if (rpc !== 4'h0) begin n_bad++; $display("FAIL mid_pc got=%h exp=0", rpc); end
    n_cmp++; if (LOAD !== 4'b1111) begin n_bad++; $display("FAIL mid_idle_load got=%b exp=1111", LOAD); end
    run_instr(el, wl, wd, wc, pl, pd, fl);
    n_cmp++; if (wl !== 4'b1110) begin n_bad++; $display("FAIL restart_wb_load got=%b exp=1110", wl); end
    n_cmp++; if (wd !== 4'h7) begin n_bad++; $display("FAIL restart_wb_data got=%h exp=7", wd); end
    n_cmp++; if (ra !== 4'h7) begin n_bad++; $display("FAIL restart_reg_a got=%h exp=7", ra); end
    n_cmp++; if (rpc !== 4'h1) begin n_bad++; $display("FAIL restart_pc got=%h exp=1", rpc); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    test_reset();
    test_add_overflow();
    test_jnc();
    test_jmp_wrap();
    test_out_undefined();
    test_run_hold();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
